// File: rtl/alu_md_pkg.sv
// Shared encodings for the M-extension multiply/divide unit.
package alu_md_pkg;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  localparam logic [6:0] M_FUNCT7    = 7'b0000001;
  localparam logic [2:0] ALUOP_RTYPE = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mdState_e;

endpackage

// File: rtl/alu_md_iter.sv
// One iteration of the multiply (shift-add) or restoring divide (shift-subtract).
// acc holds {hi, lo}: product accumulator for multiply, {remainder, quotient/dividend} for divide.
module alu_md_iter
  import alu_md_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              isDiv,
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   b,
  output logic [2*XLEN-1:0] accNext
);

  logic [XLEN:0] sum, trial, diff;

  always_comb begin
    sum     = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, b};
    trial   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    diff    = trial - {1'b0, b};
    accNext = '0;
    if (isDiv) begin
      // a borrow out of diff means the trial remainder is below the divisor
      if (!diff[XLEN]) accNext = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      else             accNext = {trial[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end else if (acc[0]) begin
      accNext = {sum, acc[XLEN-1:1]};
    end else begin
      accNext = {1'b0, acc[2*XLEN-1:1]};
    end
  end

endmodule

// File: rtl/alu_md_unit.sv
// Iterative RV32M/RV64M multiply/divide unit with valid/ready handshake.
// Operates on magnitudes and applies the result sign in a single FIX cycle.
module alu_md_unit
  import alu_md_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            iClk,
  input  logic            iRstN,
  input  logic [2:0]      iAluOp,
  input  logic [2:0]      iFunct3,
  input  logic [6:0]      iFunct7,
  input  logic [XLEN-1:0] iRs1,
  input  logic [XLEN-1:0] iRs2,
  input  logic            iValid,
  output logic            oReady,
  input  logic            iFlush,
  output logic            oIsMd,
  output logic [XLEN-1:0] oResult,
  output logic            oValid,
  input  logic            iReady
);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  mdState_e          state, nextState;
  logic [CNT_W-1:0]  cnt;
  logic [2*XLEN-1:0] acc, accNext, prodS;
  logic [XLEN-1:0]   opnd, magA, magB, fastRes, fixRes, quoS, remS;
  logic [2:0]        op;
  logic              neg, sA, sB, accept, isDiv, divOvf, fast;

  assign oIsMd  = (iAluOp == ALUOP_RTYPE) && (iFunct7 == M_FUNCT7);
  assign oReady = (state == IDLE);
  assign oValid = (state == DONE);
  assign isDiv  = iFunct3[2];
  assign accept = oReady && iValid && oIsMd && !iFlush;

  // Request-side decode: operand signedness, magnitudes and fast-path result
  always_comb begin
    sA = 1'b0;
    sB = 1'b0;
    case (iFunct3)
      MD_MULH, MD_DIV, MD_REM: begin
        sA = iRs1[XLEN-1];
        sB = iRs2[XLEN-1];
      end
      MD_MULHSU: sA = iRs1[XLEN-1];
      default: ;
    endcase
    magA    = sA ? -iRs1 : iRs1;
    magB    = sB ? -iRs2 : iRs2;
    divOvf  = (iFunct3 == MD_DIV || iFunct3 == MD_REM) && (iRs1 == MIN_NEG) && (&iRs2);
    fast    = isDiv && ((iRs2 == '0) || divOvf);
    if (iRs2 == '0) fastRes = iFunct3[1] ? iRs1 : '1;
    else            fastRes = iFunct3[1] ? '0 : iRs1;
  end

  alu_md_iter #(.XLEN(XLEN)) uIter (
    .isDiv  (op[2]),
    .acc    (acc),
    .b      (opnd),
    .accNext(accNext)
  );

  always_comb begin
    prodS = neg ? -acc : acc;
    quoS  = neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    remS  = neg ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    case (op)
      MD_MUL:                       fixRes = prodS[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: fixRes = prodS[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              fixRes = quoS;
      default:                      fixRes = remS;
    endcase
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: if (accept) nextState = fast ? DONE : CALC;
      CALC: begin
        if (iFlush)                 nextState = IDLE;
        else if (cnt == CNT_W'(1))  nextState = FIX;
      end
      FIX:  nextState = iFlush ? IDLE : DONE;
      DONE: if (iFlush || iReady) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) state <= IDLE;
    else        state <= nextState;
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      cnt     <= '0;
      acc     <= '0;
      opnd    <= '0;
      op      <= MD_MUL;
      neg     <= 1'b0;
      oResult <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op  <= iFunct3;
          neg <= (iFunct3[2] && iFunct3[1]) ? sA : (sA ^ sB);
          cnt <= CNT_W'(XLEN);
          // multiply iterates over B in the low word; divide shifts the dividend out of it
          if (isDiv) begin
            opnd <= magB;
            acc  <= {{XLEN{1'b0}}, magA};
          end else begin
            opnd <= magA;
            acc  <= {{XLEN{1'b0}}, magB};
          end
          if (fast) oResult <= fastRes;
        end
        CALC: begin
          acc <= accNext;
          cnt <= cnt - CNT_W'(1);
        end
        FIX: if (!iFlush) oResult <= fixRes;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_md_unit.sv
// Directed and randomized checks of alu_md_unit (XLEN=32) against an arithmetic reference.
module tb_alu_md_unit;

  localparam int XLEN = 32;

  logic            iClk = 1'b0;
  logic            iRstN;
  logic [2:0]      iAluOp;
  logic [2:0]      iFunct3;
  logic [6:0]      iFunct7;
  logic [XLEN-1:0] iRs1, iRs2;
  logic            iValid, oReady, iFlush, oIsMd, oValid, iReady;
  logic [XLEN-1:0] oResult;

  int checks = 0;
  int failures = 0;

  alu_md_unit #(.XLEN(XLEN)) dut (
    .iClk(iClk), .iRstN(iRstN), .iAluOp(iAluOp), .iFunct3(iFunct3), .iFunct7(iFunct7),
    .iRs1(iRs1), .iRs2(iRs2), .iValid(iValid), .oReady(oReady), .iFlush(iFlush),
    .oIsMd(oIsMd), .oResult(oResult), .oValid(oValid), .iReady(iReady)
  );

  always #5 iClk = ~iClk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // RISC-V M semantics computed with 64-bit arithmetic
  function automatic logic [31:0] refMd(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ub;
    longint unsigned ua, ubu;
    logic [63:0] p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ub = {32'd0, b};
    ua = {32'd0, a};
    ubu = {32'd0, b};
    p = '0;
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ubu; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFFFFFF;
        p = ua / ubu; return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ubu; return p[31:0];
      end
    endcase
  endfunction

  function automatic int refLat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 0)) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
    return XLEN + 2;
  endfunction

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge iClk);
    iAluOp = 3'b010; iFunct7 = 7'b0000001; iFunct3 = f; iRs1 = a; iRs2 = b; iValid = 1'b1;
    @(posedge iClk);
    #1 iValid = 1'b0;
  endtask

  // Issue one op, measure edges to oValid (accept edge counts as 1), check result and return to IDLE
  task automatic runOp(input string tag, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int expLat);
    int lat;
    issue(f, a, b);
    lat = 1;
    while (!oValid && lat < 100) begin
      @(posedge iClk); #1; lat++;
    end
    chk({tag, "_lat"}, 64'(lat), 64'(expLat));
    chk({tag, "_res"}, 64'(oResult), 64'(exp));
    @(posedge iClk); #1;
    chk({tag, "_idle"}, 64'({oReady, oValid}), 64'(2'b10));
  endtask

  initial begin
    logic [31:0] a, b, held;
    logic [2:0]  f;
    int          seen;

    iRstN = 1'b0; iAluOp = 3'b000; iFunct3 = 3'b000; iFunct7 = 7'b0; iRs1 = '0; iRs2 = '0;
    iValid = 1'b0; iFlush = 1'b0; iReady = 1'b1;
    repeat (3) @(posedge iClk);
    #1 chk("rst_valid", 64'(oValid), 64'(0));
    chk("rst_result", 64'(oResult), 64'(0));
    @(negedge iClk) iRstN = 1'b1;
    @(posedge iClk); #1;
    chk("rst_ready", 64'(oReady), 64'(1));

    // Basic, high-word and fast-path directed cases
    runOp("mul",    3'd0, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 34);
    runOp("div",    3'd4, 32'hFFFFFFEC,   32'd6,        32'hFFFFFFFD, 34);
    runOp("rem",    3'd6, 32'hFFFFFFEC,   32'd6,        32'hFFFFFFFE, 34);
    runOp("mulh",   3'd1, 32'h80000000,   32'h80000000, 32'h40000000, 34);
    runOp("mulhu",  3'd3, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 34);
    runOp("mulhsu", 3'd2, 32'hFFFFFFFF,   32'd2,        32'hFFFFFFFF, 34);
    runOp("divu0",  3'd5, 32'd5,          32'd0,        32'hFFFFFFFF, 1);
    runOp("rem0",   3'd6, 32'd5,          32'd0,        32'd5,        1);
    runOp("divovf", 3'd4, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1);
    runOp("removf", 3'd6, 32'h80000000,   32'hFFFFFFFF, 32'd0,        1);

    // Randomized ops with corner-biased operands
    for (int i = 0; i < 24; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = '0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: begin a = 32'($urandom_range(0, 50)); b = 32'($urandom_range(1, 9)); end
        3: b = -32'($urandom_range(1, 9));
        default: ;
      endcase
      runOp($sformatf("rnd%0d_f%0d", i, f), f, a, b, refMd(f, a, b), refLat(f, a, b));
    end

    // Back-pressure: result must hold while iReady is low
    iReady = 1'b0;
    issue(3'd0, 32'd1234, 32'd5678);
    seen = 1;
    while (!oValid && seen < 100) begin @(posedge iClk); #1; seen++; end
    held = oResult;
    chk("bp_res", 64'(held), 64'(refMd(3'd0, 32'd1234, 32'd5678)));
    for (int i = 0; i < 10; i++) begin
      @(posedge iClk); #1;
      chk("bp_hold", 64'({oValid, oReady, oResult}), 64'({1'b1, 1'b0, held}));
    end
    @(negedge iClk) iReady = 1'b1;
    @(posedge iClk); #1;
    chk("bp_release", 64'({oValid, oReady}), 64'(2'b01));

    // Decode: funct7=0 is not an M-op and must be ignored
    @(negedge iClk);
    iAluOp = 3'b010; iFunct7 = 7'b0; iFunct3 = 3'd0; iRs1 = 32'd3; iRs2 = 32'd4; iValid = 1'b1;
    #1 chk("dec_ismd0", 64'(oIsMd), 64'(0));
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge iClk); #1;
      if (oValid || !oReady) seen++;
    end
    chk("dec_noaccept", 64'(seen), 64'(0));
    iValid = 1'b0; iFunct7 = 7'b0000001;
    #1 chk("dec_ismd1", 64'(oIsMd), 64'(1));
    iAluOp = 3'b000;
    #1 chk("dec_aluop", 64'(oIsMd), 64'(0));

    // Flush in the 10th CALC cycle
    issue(3'd5, 32'd1000, 32'd7);
    repeat (9) @(posedge iClk);
    @(negedge iClk) iFlush = 1'b1;
    @(posedge iClk); #1 iFlush = 1'b0;
    chk("flush_idle", 64'({oValid, oReady}), 64'(2'b01));
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge iClk); #1;
      if (oValid) seen++;
    end
    chk("flush_novalid", 64'(seen), 64'(0));
    runOp("post_flush", 3'd7, 32'd1000, 32'd7, 32'd6, 34);

    // Async reset mid-CALC
    issue(3'd0, 32'hDEAD, 32'hBEEF);
    repeat (5) @(posedge iClk);
    #2 iRstN = 1'b0;
    #1 chk("mrst_state", 64'({oValid, oReady}), 64'(2'b01));
    chk("mrst_result", 64'(oResult), 64'(0));
    @(negedge iClk) iRstN = 1'b1;
    runOp("post_rst", 3'd0, 32'hDEAD, 32'hBEEF, refMd(3'd0, 32'hDEAD, 32'hBEEF), 34);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
